// File: rtl/irq_arbiter.sv
// Interrupt arbiter: shares one core irq_req/irq_ret pair among N level-triggered sources,
// with fixed-priority or round-robin grant and a small bus-mapped register file.
module irq_arbiter #(
  parameter int             N          = 3,
  parameter logic [N-1:0]   RESET_MASK = {N{1'b1}}
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              req_i,
  input  logic              write_enable_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       read_data_o,
  input  logic [N-1:0]      src_req_i,
  output logic [N-1:0]      src_ret_o,
  output logic              irq_req_o,
  input  logic              irq_ret_i
);

  localparam int ID_W = 3;

  localparam logic [23:0] ADDR_ENABLE  = 24'h00_0000;
  localparam logic [23:0] ADDR_PENDING = 24'h00_0004;
  localparam logic [23:0] ADDR_ACTIVE  = 24'h00_0008;
  localparam logic [23:0] ADDR_MODE    = 24'h00_000C;
  localparam logic [23:0] ADDR_COUNT   = 24'h00_0010;

  typedef enum logic [1:0] {IDLE, BUSY, RET} state_t;

  state_t          state_q;
  logic [N-1:0]    enable_q;
  logic            mode_q;
  logic [15:0]     count_q;
  logic [ID_W-1:0] active_id_q;
  logic [ID_W-1:0] last_id_q;

  logic [N-1:0]    pending;
  logic [ID_W-1:0] winner;
  logic            bus_wr;
  logic            bus_rd;
  logic [31:0]     read_mux;
  logic            unused_bits;

  // Fixed mode scans 0..N-1; round-robin scans last_id+1 .. last_id+N (mod N).
  function automatic logic [ID_W-1:0] pick_winner(input logic [N-1:0]    p,
                                                  input logic            rr,
                                                  input logic [ID_W-1:0] last);
    logic [ID_W-1:0] win;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (rr) idx = (int'(last) + k) % N;
      else    idx = k - 1;
      if (!found && p[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [N-1:0] one_hot(input logic [ID_W-1:0] id);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (ID_W'(i) == id);
    return r;
  endfunction

  assign pending     = src_req_i & enable_q;
  assign winner      = pick_winner(pending, mode_q, last_id_q);
  assign bus_wr      = req_i & write_enable_i;
  assign bus_rd      = req_i & ~write_enable_i;
  assign unused_bits = ^{addr_i[31:24], write_data_i[31:N]};

  always_comb begin
    read_mux = '0;
    case (addr_i[23:0])
      ADDR_ENABLE:  read_mux = {{(32-N){1'b0}}, enable_q};
      ADDR_PENDING: read_mux = {{(32-N){1'b0}}, pending};
      ADDR_ACTIVE:  read_mux = {(state_q != IDLE), 28'b0, active_id_q};
      ADDR_MODE:    read_mux = {31'b0, mode_q};
      ADDR_COUNT:   read_mux = {16'b0, count_q};
      default:      read_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      irq_req_o   <= 1'b0;
      src_ret_o   <= '0;
      active_id_q <= '0;
      last_id_q   <= ID_W'(N - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending) begin
            active_id_q <= winner;
            last_id_q   <= winner;
            irq_req_o   <= 1'b1;
            state_q     <= BUSY;
          end
        end
        // The grant holds regardless of ENABLE or the source's request until the core returns.
        BUSY: begin
          if (irq_ret_i) begin
            irq_req_o <= 1'b0;
            src_ret_o <= one_hot(active_id_q);
            state_q   <= RET;
          end
        end
        RET: begin
          src_ret_o <= '0;
          state_q   <= IDLE;
        end
        default: begin
          irq_req_o <= 1'b0;
          src_ret_o <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      enable_q    <= RESET_MASK;
      mode_q      <= 1'b0;
      count_q     <= '0;
      read_data_o <= '0;
    end else begin
      if (bus_wr && addr_i[23:0] == ADDR_ENABLE) enable_q <= write_data_i[N-1:0];
      if (bus_wr && addr_i[23:0] == ADDR_MODE)   mode_q   <= write_data_i[0];
      // A software clear beats the completion increment in the same cycle.
      if (bus_wr && addr_i[23:0] == ADDR_COUNT)  count_q  <= '0;
      else if (state_q == RET)                   count_q  <= count_q + 16'd1;
      if (bus_rd) read_data_o <= read_mux;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter (N=3): expected grants are queued when stimulus is applied
// and popped when the arbiter raises irq_req_o.
module tb_irq_arbiter;

  localparam logic [31:0] A_ENABLE  = 32'h0800_0000;
  localparam logic [31:0] A_PENDING = 32'h0800_0004;
  localparam logic [31:0] A_ACTIVE  = 32'h0800_0008;
  localparam logic [31:0] A_MODE    = 32'h0800_000C;
  localparam logic [31:0] A_COUNT   = 32'h0800_0010;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [2:0]  src_req;
  logic [2:0]  src_ret;
  logic        irq_req;
  logic        irq_ret;

  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];

  irq_arbiter #(.N(3), .RESET_MASK(3'b111)) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .req_i          (req),
    .write_enable_i (we),
    .addr_i         (addr),
    .write_data_i   (wdata),
    .read_data_o    (rdata),
    .src_req_i      (src_req),
    .src_ret_o      (src_ret),
    .irq_req_o      (irq_req),
    .irq_ret_i      (irq_ret)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] oh(input logic [2:0] id);
    logic [2:0] one;
    one = 3'b001;
    return one << id;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; addr = a;
    step();
    req = 1'b0;
    check(tag, rdata, exp);
  endtask

  // Services one interrupt: expects the queued grant, returns it, and drops that source.
  task automatic serve(input string tag);
    logic [31:0] e;
    logic [2:0]  id;
    int          n;
    e  = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    id = e[2:0];
    n  = 0;
    while (irq_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"}, 32'(irq_req), 32'd1);
    read_check({tag, "_active"}, A_ACTIVE, e);
    irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;
    check({tag, "_ret_pulse"}, 32'(src_ret), 32'(oh(id)));
    check({tag, "_req_low"}, 32'(irq_req), 32'd0);
    src_req = src_req & ~oh(id);
    step();
    check({tag, "_ret_clear"}, 32'(src_ret), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    src_req = '0; irq_ret = 1'b0;
    repeat (3) step();
    check("rst_irq_req", 32'(irq_req), 32'd0);
    check("rst_src_ret", 32'(src_ret), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;
    step();
    read_check("rst_enable", A_ENABLE, 32'd7);
    read_check("rst_mode", A_MODE, 32'd0);
    read_check("rst_count", A_COUNT, 32'd0);
    read_check("rst_active", A_ACTIVE, 32'd0);
    read_check("unmapped", 32'h0800_0020, 32'd0);

    // Single source, fixed mode, one-cycle request latency.
    src_req = 3'b010;
    step();
    check("t1_latency", 32'(irq_req), 32'd1);
    exp_q.push_back(32'h8000_0001);
    serve("t1");
    read_check("t1_count", A_COUNT, 32'd1);

    // Fixed priority: 1 before 2.
    src_req = 3'b110;
    exp_q.push_back(32'h8000_0001);
    exp_q.push_back(32'h8000_0002);
    serve("fix_a");
    serve("fix_b");

    // Round-robin with all sources re-asserted after each return.
    bus_write(A_MODE, 32'd1);
    read_check("mode_rw", A_MODE, 32'd1);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0001);
    exp_q.push_back(32'h8000_0002);
    exp_q.push_back(32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      src_req = 3'b111;
      serve("rr");
    end
    src_req = 3'b000;
    bus_write(A_MODE, 32'd0);
    read_check("count_7", A_COUNT, 32'd7);

    // Masked source never requests and is not pending.
    bus_write(A_ENABLE, 32'hFFFF_FFF5);
    read_check("enable_upper", A_ENABLE, 32'd5);
    src_req = 3'b010;
    step();
    step();
    check("mask_no_req", 32'(irq_req), 32'd0);
    read_check("mask_pending", A_PENDING, 32'd0);
    src_req = 3'b000;

    // Clearing ENABLE while BUSY does not abort the grant.
    bus_write(A_ENABLE, 32'd7);
    src_req = 3'b001;
    step();
    check("busy_enter", 32'(irq_req), 32'd1);
    read_check("busy_pending", A_PENDING, 32'd1);
    bus_write(A_ENABLE, 32'd0);
    src_req = 3'b000;
    repeat (3) step();
    check("busy_hold", 32'(irq_req), 32'd1);
    exp_q.push_back(32'h8000_0000);
    serve("mask_busy");
    bus_write(A_ENABLE, 32'd7);
    read_check("count_8", A_COUNT, 32'd8);

    // COUNT write in the RET cycle wins over the increment.
    src_req = 3'b001;
    step();
    irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;
    check("cw_ret", 32'(src_ret), 32'd1);
    src_req = 3'b000;
    bus_write(A_COUNT, 32'h0000_1234);
    read_check("cw_count", A_COUNT, 32'd0);

    // COUNT wraps from 0xFFFF to 0 on the next completed service.
    force dut.count_q = 16'hFFFF;
    release dut.count_q;
    src_req = 3'b001;
    exp_q.push_back(32'h8000_0000);
    serve("wrap");
    read_check("wrap_count", A_COUNT, 32'd0);

    // irq_ret_i while IDLE is ignored.
    irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;
    check("idle_ret_src", 32'(src_ret), 32'd0);
    check("idle_ret_req", 32'(irq_req), 32'd0);
    step();
    check("idle_ret_src2", 32'(src_ret), 32'd0);
    read_check("idle_active", A_ACTIVE, 32'd0);

    // Asynchronous reset in the middle of a service.
    bus_write(A_MODE, 32'd1);
    bus_write(A_ENABLE, 32'd3);
    src_req = 3'b010;
    step();
    check("mid_busy", 32'(irq_req), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_async", 32'(irq_req), 32'd0);
    src_req = 3'b000;
    step();
    check("mid_rst_noret", 32'(src_ret), 32'd0);
    step();
    check("mid_rst_noret2", 32'(src_ret), 32'd0);
    resetn = 1'b1;
    step();
    check("mid_rst_noret3", 32'(src_ret), 32'd0);
    read_check("mid_enable", A_ENABLE, 32'd7);
    read_check("mid_mode", A_MODE, 32'd0);
    read_check("mid_count", A_COUNT, 32'd0);
    read_check("mid_active", A_ACTIVE, 32'd0);

    // First round-robin grant after reset goes to source 0.
    bus_write(A_MODE, 32'd1);
    src_req = 3'b011;
    exp_q.push_back(32'h8000_0000);
    serve("rr_after_rst");
    src_req = 3'b000;

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
